// File: rtl/ysyx_25040129_arbiter.sv
// rtl/ysyx_25040129_arbiter.sv - two-master (IFU/LSU) to single AXI-lite master arbiter
//
// Purpose:
//   Shares one AXI-lite style master port between the instruction fetch unit
//   (read only) and the load/store unit (read and write). At most one
//   transaction is in flight. The grant is registered: a request seen in IDLE
//   enters its forwarding state on the next edge, and each completed
//   transaction returns through one IDLE cycle before the next grant.
//   IFU/LSU ties go to whichever side was not granted last; within the LSU a
//   read beats a write.
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   ifu_ar*/ifu_r*                 IFU read address / read data channels
//   lsu_ar*/lsu_r*                 LSU read address / read data channels
//   lsu_aw*/lsu_w*/lsu_b*          LSU write address / write data / response
//   ar*/r*/aw*/w*/b*               shared master side towards the crossbar
//
// Parameters:
//   IFU_ARSIZE                     arsize driven for every IFU fetch

module ysyx_25040129_arbiter #(
  parameter logic [2:0] IFU_ARSIZE = 3'b010
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] ifu_araddr,
  input  logic        ifu_arvalid,
  output logic        ifu_arready,
  output logic [31:0] ifu_rdata,
  output logic [1:0]  ifu_rresp,
  output logic        ifu_rvalid,
  input  logic        ifu_rready,

  input  logic [31:0] lsu_araddr,
  input  logic [2:0]  lsu_arsize,
  input  logic        lsu_arvalid,
  output logic        lsu_arready,
  output logic [31:0] lsu_rdata,
  output logic [1:0]  lsu_rresp,
  output logic        lsu_rvalid,
  input  logic        lsu_rready,

  input  logic [31:0] lsu_awaddr,
  input  logic        lsu_awvalid,
  output logic        lsu_awready,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  input  logic        lsu_wvalid,
  output logic        lsu_wready,
  output logic [1:0]  lsu_bresp,
  output logic        lsu_bvalid,
  input  logic        lsu_bready,

  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } state_t;

  localparam logic GRANT_IFU = 1'b0;
  localparam logic GRANT_LSU = 1'b1;

  state_t state;
  state_t state_nxt;
  state_t lsu_state;
  logic   last_grant;
  logic   last_grant_nxt;
  logic   aw_done;
  logic   aw_done_nxt;
  logic   w_done;
  logic   w_done_nxt;
  // Low for the first edge after reset release, so no grant is issued on
  // that edge even if a requester is already waiting.
  logic   arb_en;

  logic   ifu_req;
  logic   lsu_rd_req;
  logic   lsu_wr_req;
  logic   lsu_req;
  logic   aw_fire;
  logic   w_fire;

  assign ifu_req    = ifu_arvalid;
  assign lsu_rd_req = lsu_arvalid;
  assign lsu_wr_req = lsu_awvalid && lsu_wvalid;
  assign lsu_req    = lsu_rd_req || lsu_wr_req;
  assign lsu_state  = lsu_rd_req ? LSU_RD : LSU_WR;

  // AW and W may complete in either order; the done flags mask the
  // channel afterwards so each is issued exactly once per write.
  assign aw_fire = (state == LSU_WR) && lsu_awvalid && !aw_done && awready;
  assign w_fire  = (state == LSU_WR) && lsu_wvalid  && !w_done  && wready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= GRANT_IFU;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      arb_en     <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      aw_done    <= aw_done_nxt;
      w_done     <= w_done_nxt;
      arb_en     <= 1'b1;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    aw_done_nxt    = aw_done;
    w_done_nxt     = w_done;

    ifu_arready = 1'b0;
    ifu_rdata   = 32'h0;
    ifu_rresp   = 2'b00;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = 32'h0;
    lsu_rresp   = 2'b00;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bresp   = 2'b00;
    lsu_bvalid  = 1'b0;
    araddr      = 32'h0;
    arsize      = 3'b000;
    arvalid     = 1'b0;
    rready      = 1'b0;
    awaddr      = 32'h0;
    awvalid     = 1'b0;
    wdata       = 32'h0;
    wstrb       = 4'b0000;
    wvalid      = 1'b0;
    bready      = 1'b0;

    case (state)
      IDLE: begin
        if (arb_en) begin
          if (ifu_req && lsu_req) begin
            state_nxt = (last_grant == GRANT_IFU) ? lsu_state : IFU_RD;
          end else if (ifu_req) begin
            state_nxt = IFU_RD;
          end else if (lsu_req) begin
            state_nxt = lsu_state;
          end
        end
      end

      IFU_RD: begin
        araddr      = ifu_araddr;
        arsize      = IFU_ARSIZE;
        arvalid     = ifu_arvalid;
        ifu_arready = arready;
        ifu_rdata   = rdata;
        ifu_rresp   = rresp;
        ifu_rvalid  = rvalid;
        rready      = ifu_rready;
        if (rvalid && ifu_rready) begin
          state_nxt      = IDLE;
          last_grant_nxt = GRANT_IFU;
        end
      end

      LSU_RD: begin
        araddr      = lsu_araddr;
        arsize      = lsu_arsize;
        arvalid     = lsu_arvalid;
        lsu_arready = arready;
        lsu_rdata   = rdata;
        lsu_rresp   = rresp;
        lsu_rvalid  = rvalid;
        rready      = lsu_rready;
        if (rvalid && lsu_rready) begin
          state_nxt      = IDLE;
          last_grant_nxt = GRANT_LSU;
        end
      end

      LSU_WR: begin
        awaddr      = lsu_awaddr;
        awvalid     = lsu_awvalid && !aw_done;
        lsu_awready = awready && !aw_done;
        wdata       = lsu_wdata;
        wstrb       = lsu_wstrb;
        wvalid      = lsu_wvalid && !w_done;
        lsu_wready  = wready && !w_done;
        lsu_bresp   = bresp;
        lsu_bvalid  = bvalid;
        bready      = lsu_bready;
        if (aw_fire) begin
          aw_done_nxt = 1'b1;
        end
        if (w_fire) begin
          w_done_nxt = 1'b1;
        end
        // Leaving the state wins over any same-cycle set so the flags
        // always start clear for the next write.
        if (bvalid && lsu_bready) begin
          state_nxt      = IDLE;
          last_grant_nxt = GRANT_LSU;
          aw_done_nxt    = 1'b0;
          w_done_nxt     = 1'b0;
        end
      end

      default: begin
        state_nxt   = IDLE;
        aw_done_nxt = 1'b0;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_25040129_arbiter.sv
// tb/tb_ysyx_25040129_arbiter.sv - directed self-checking bench for the IFU/LSU arbiter

module tb_ysyx_25040129_arbiter;

  localparam logic [31:0] IFU_ADDR = 32'h3000_0000;
  localparam logic [31:0] LSU_ADDR = 32'h8000_0040;
  localparam logic [31:0] WR_ADDR  = 32'h1000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic        ifu_arready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rvalid;
  logic        ifu_rready;
  logic [31:0] lsu_araddr;
  logic [2:0]  lsu_arsize;
  logic        lsu_arvalid;
  logic        lsu_arready;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        lsu_rvalid;
  logic        lsu_rready;
  logic [31:0] lsu_awaddr;
  logic        lsu_awvalid;
  logic        lsu_awready;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic        lsu_wvalid;
  logic        lsu_wready;
  logic [1:0]  lsu_bresp;
  logic        lsu_bvalid;
  logic        lsu_bready;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int total;
  int bad;
  int w_beats;
  int aw_beats;
  int beats_w0;
  int beats_aw0;

  ysyx_25040129_arbiter #(.IFU_ARSIZE(3'b010)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat counters on the master side, used to prove single-issue of AW/W.
  always @(posedge clk) begin
    if (wvalid && wready) w_beats <= w_beats + 1;
    if (awvalid && awready) aw_beats <= aw_beats + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_bus;
    ifu_arvalid = 1'b0;
    lsu_arvalid = 1'b0;
    lsu_awvalid = 1'b0;
    lsu_wvalid  = 1'b0;
    arready     = 1'b0;
    awready     = 1'b0;
    wready      = 1'b0;
    rvalid      = 1'b0;
    bvalid      = 1'b0;
    rdata       = 32'h0;
    rresp       = 2'b00;
    bresp       = 2'b00;
    ifu_rready  = 1'b1;
    lsu_rready  = 1'b1;
    lsu_bready  = 1'b1;
  endtask

  // 0 = nothing forwarded, 1 = IFU read, 2 = LSU read, 3 = LSU write
  function automatic logic [1:0] observed();
    if (awvalid) return 2'd3;
    if (arvalid && araddr == IFU_ADDR) return 2'd1;
    if (arvalid && araddr == LSU_ADDR) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic any_out();
    return |{ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid,
             lsu_arready, lsu_rdata, lsu_rresp, lsu_rvalid,
             lsu_awready, lsu_wready, lsu_bresp, lsu_bvalid,
             araddr, arsize, arvalid, rready, awaddr, awvalid,
             wdata, wstrb, wvalid, bready};
  endfunction

  typedef struct {
    logic       ifu;
    logic       lrd;
    logic       lwr;
    logic [1:0] exp;
  } vec_t;

  vec_t vecs [9];

  initial begin
    total = 0;
    bad = 0;
    w_beats = 0;
    aw_beats = 0;

    // Arbitration table, applied straight after reset (last grant = IFU).
    vecs[0] = '{1'b1, 1'b1, 1'b0, 2'd2};  // first tie: LSU
    vecs[1] = '{1'b1, 1'b1, 1'b0, 2'd1};  // second tie: IFU
    vecs[2] = '{1'b1, 1'b1, 1'b0, 2'd2};  // third tie: LSU again
    vecs[3] = '{1'b1, 1'b0, 1'b0, 2'd1};  // IFU alone
    vecs[4] = '{1'b0, 1'b1, 1'b1, 2'd2};  // LSU read beats LSU write
    vecs[5] = '{1'b0, 1'b0, 1'b1, 2'd3};  // LSU write alone
    vecs[6] = '{1'b1, 1'b0, 1'b1, 2'd1};  // tie after LSU: IFU
    vecs[7] = '{1'b1, 1'b0, 1'b1, 2'd3};  // tie after IFU: LSU write
    vecs[8] = '{1'b0, 1'b0, 1'b0, 2'd0};  // no request: stay idle

    ifu_araddr = IFU_ADDR;
    lsu_araddr = LSU_ADDR;
    lsu_arsize = 3'b010;
    lsu_awaddr = WR_ADDR;
    lsu_wdata  = 32'h0000_0041;
    lsu_wstrb  = 4'b0001;
    idle_bus();
    rst = 1'b0;
    #12;
    chk("reset_outputs_zero", any_out(), 1'b0);
    tick();
    rst = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 9; i++) begin
      ifu_arvalid = vecs[i].ifu;
      lsu_arvalid = vecs[i].lrd;
      lsu_awvalid = vecs[i].lwr;
      lsu_wvalid  = vecs[i].lwr;
      settle();
      chk($sformatf("idle_quiet[%0d]", i), observed(), 2'd0);
      tick();
      settle();
      chk($sformatf("grant[%0d]", i), observed(), vecs[i].exp);
      if (vecs[i].exp != 2'd0) begin
        arready = 1'b1;
        awready = 1'b1;
        wready  = 1'b1;
        rvalid  = 1'b1;
        bvalid  = 1'b1;
        tick();
        settle();
        chk($sformatf("back_idle[%0d]", i), observed(), 2'd0);
      end
      idle_bus();
    end

    // IFU fetch with immediate arready and late read data.
    ifu_arvalid = 1'b1;
    tick();
    arready = 1'b1;
    settle();
    chk("fetch_arvalid", arvalid, 1'b1);
    chk("fetch_araddr", araddr, IFU_ADDR);
    chk("fetch_arsize", arsize, 3'b010);
    chk("fetch_arready", ifu_arready, 1'b1);
    chk("fetch_lsu_arready", lsu_arready, 1'b0);
    tick();
    ifu_arvalid = 1'b0;
    arready = 1'b0;
    tick();
    tick();
    rvalid = 1'b1;
    rdata = 32'hDEAD_BEEF;
    settle();
    chk("fetch_rvalid", ifu_rvalid, 1'b1);
    chk("fetch_rdata", ifu_rdata, 32'hDEAD_BEEF);
    chk("fetch_rready", rready, 1'b1);
    tick();
    settle();
    chk("fetch_idle_rvalid", ifu_rvalid, 1'b0);
    chk("fetch_idle_rdata", ifu_rdata, 32'h0);
    idle_bus();

    // LSU read returning an error response.
    lsu_arsize = 3'b000;
    lsu_arvalid = 1'b1;
    tick();
    arready = 1'b1;
    settle();
    chk("lrd_arsize", arsize, 3'b000);
    chk("lrd_araddr", araddr, LSU_ADDR);
    chk("lrd_arready", lsu_arready, 1'b1);
    chk("lrd_ifu_arready", ifu_arready, 1'b0);
    tick();
    lsu_arvalid = 1'b0;
    arready = 1'b0;
    rvalid = 1'b1;
    rresp = 2'b11;
    rdata = 32'h1234_5678;
    settle();
    chk("lrd_rresp", lsu_rresp, 2'b11);
    chk("lrd_rdata", lsu_rdata, 32'h1234_5678);
    chk("lrd_ifu_rvalid", ifu_rvalid, 1'b0);
    tick();
    settle();
    chk("lrd_idle", lsu_rvalid, 1'b0);
    idle_bus();

    // Long LSU read while the IFU keeps requesting.
    lsu_arvalid = 1'b1;
    tick();
    ifu_arvalid = 1'b1;
    arready = 1'b1;
    tick();
    lsu_arvalid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      settle();
      chk($sformatf("ifu_blocked[%0d]", c), ifu_arready, 1'b0);
      tick();
    end
    rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    settle();
    chk("gap_idle", arvalid, 1'b0);
    tick();
    settle();
    chk("ifu_after_lsu", observed(), 2'd1);
    chk("ifu_after_lsu_arready", ifu_arready, 1'b1);
    tick();
    ifu_arvalid = 1'b0;
    arready = 1'b0;
    rvalid = 1'b1;
    tick();
    idle_bus();

    // LSU write: W accepted three cycles before AW.
    beats_w0 = w_beats;
    beats_aw0 = aw_beats;
    lsu_awvalid = 1'b1;
    lsu_wvalid = 1'b1;
    tick();
    wready = 1'b1;
    settle();
    chk("wr_awvalid", awvalid, 1'b1);
    chk("wr_wvalid", wvalid, 1'b1);
    chk("wr_awaddr", awaddr, WR_ADDR);
    chk("wr_wdata", wdata, 32'h0000_0041);
    chk("wr_wstrb", wstrb, 4'b0001);
    chk("wr_lsu_wready", lsu_wready, 1'b1);
    tick();
    settle();
    chk("wr_wvalid_dropped", wvalid, 1'b0);
    chk("wr_lsu_wready_masked", lsu_wready, 1'b0);
    chk("wr_awvalid_held", awvalid, 1'b1);
    tick();
    tick();
    awready = 1'b1;
    settle();
    chk("wr_awvalid_at_awready", awvalid, 1'b1);
    chk("wr_lsu_awready", lsu_awready, 1'b1);
    tick();
    settle();
    chk("wr_awvalid_dropped", awvalid, 1'b0);
    chk("wr_lsu_awready_masked", lsu_awready, 1'b0);
    bvalid = 1'b1;
    bresp = 2'b10;
    settle();
    chk("wr_bvalid", lsu_bvalid, 1'b1);
    chk("wr_bresp", lsu_bresp, 2'b10);
    chk("wr_bready", bready, 1'b1);
    tick();
    settle();
    chk("wr_idle", lsu_bvalid, 1'b0);
    chk("wr_w_beats", w_beats - beats_w0, 1);
    chk("wr_aw_beats", aw_beats - beats_aw0, 1);
    idle_bus();

    // Reset in the middle of a write, after the AW handshake.
    lsu_awvalid = 1'b1;
    lsu_wvalid = 1'b1;
    tick();
    awready = 1'b1;
    tick();
    awready = 1'b0;
    settle();
    chk("rw_aw_done", awvalid, 1'b0);
    chk("rw_wvalid", wvalid, 1'b1);
    ifu_arvalid = 1'b1;
    bvalid = 1'b1;
    rst = 1'b0;
    #1;
    chk("rw_reset_all_zero", any_out(), 1'b0);
    tick();
    lsu_awvalid = 1'b0;
    lsu_wvalid = 1'b0;
    bvalid = 1'b0;
    rst = 1'b1;
    tick();
    settle();
    chk("rw_first_edge_no_grant", arvalid, 1'b0);
    tick();
    settle();
    chk("rw_ifu_granted", observed(), 2'd1);
    arready = 1'b1;
    tick();
    ifu_arvalid = 1'b0;
    arready = 1'b0;
    rvalid = 1'b1;
    rdata = 32'hCAFE_F00D;
    settle();
    chk("rw_ifu_rdata", ifu_rdata, 32'hCAFE_F00D);
    tick();
    idle_bus();
    lsu_awvalid = 1'b1;
    lsu_wvalid = 1'b1;
    tick();
    settle();
    chk("rw_aw_done_cleared", awvalid, 1'b1);
    chk("rw_w_done_cleared", wvalid, 1'b1);
    awready = 1'b1;
    wready = 1'b1;
    bvalid = 1'b1;
    tick();
    idle_bus();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_25040129_arbiter.md
YSYX_25040129_ARBITER -- requirements
Module: ysyx_25040129_arbiter

Interface
REQ-001 SHALL have parameter IFU_ARSIZE, default 3'b010, arsize driven for every IFU fetch.
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have IFU read ports: ifu_araddr in 32, ifu_arvalid in 1, ifu_arready out 1; ifu_rdata out 32, ifu_rresp out 2, ifu_rvalid out 1, ifu_rready in 1.
REQ-005 SHALL have LSU read ports: lsu_araddr in 32, lsu_arsize in 3, lsu_arvalid in 1, lsu_arready out 1; lsu_rdata out 32, lsu_rresp out 2, lsu_rvalid out 1, lsu_rready in 1.
REQ-006 SHALL have LSU write ports: lsu_awaddr in 32, lsu_awvalid in 1, lsu_awready out 1; lsu_wdata in 32, lsu_wstrb in 4, lsu_wvalid in 1, lsu_wready out 1; lsu_bresp out 2, lsu_bvalid out 1, lsu_bready in 1.
REQ-007 SHALL have crossbar-side master ports: araddr out 32, arsize out 3, arvalid out 1, arready in 1; rdata in 32, rresp in 2, rvalid in 1, rready out 1; awaddr out 32, awvalid out 1, awready in 1; wdata out 32, wstrb out 4, wvalid out 1, wready in 1; bresp in 2, bvalid in 1, bready out 1.

Function
REQ-008 SHALL implement states IDLE, IFU_RD, LSU_RD, LSU_WR, with at most one outstanding transaction.
REQ-009 SHALL define requests: ifu_req = ifu_arvalid; lsu_rd_req = lsu_arvalid; lsu_wr_req = lsu_awvalid && lsu_wvalid.
REQ-010 SHALL, for the LSU alone, select read over write when lsu_rd_req and lsu_wr_req are both set.
REQ-011 SHALL, when ifu_req and any LSU request are both set in IDLE, grant the requester not granted most recently (last_grant bit; reset value IFU, so the LSU wins the first tie).
REQ-012 SHALL register the grant: a request sampled in IDLE enters its state the next cycle; forwarding starts in that state (1-cycle arbitration latency). No forwarding occurs in IDLE.
REQ-013 SHALL, in IDLE, drive all valid/ready outputs on both sides to 0, and all data/addr/resp outputs to 0.
REQ-014 SHALL, in IFU_RD, forward ifu_araddr/ifu_arvalid to araddr/arvalid, drive arsize = IFU_ARSIZE, return arready to ifu_arready, forward rdata/rresp/rvalid to the IFU and ifu_rready to rready; LSU-side valid/ready outputs stay 0.
REQ-015 SHALL, in LSU_RD, forward the LSU read channels (including lsu_arsize) symmetrically; IFU-side outputs stay 0.
REQ-016 SHALL, in LSU_WR, forward AW, W, and B channels; awvalid = lsu_awvalid && !aw_done; wvalid = lsu_wvalid && !w_done.
REQ-017 SHALL set aw_done on awvalid&&awready and w_done on wvalid&&wready, in any order or the same cycle; the LSU-side ready for a done channel SHALL read 0.
REQ-018 SHALL clear aw_done and w_done on leaving LSU_WR.
REQ-019 SHALL return to IDLE on the cycle after the completing handshake: rvalid&&rready in a read state, bvalid&&bready in LSU_WR; last_grant updates on that same edge.
REQ-020 SHALL never issue a new grant in the cycle a transaction completes; back-to-back transactions are separated by one IDLE cycle.
REQ-021 SHALL pass rresp/bresp through unmodified, including non-OKAY values; the arbiter does no address decode.
REQ-022 SHALL hold its state while a granted transaction is incomplete, regardless of activity on the other requester.
REQ-023 SHALL not support withdrawal of a valid before its handshake (protocol violation; behaviour undefined).

Reset
REQ-024 SHALL, while rst = 0, force state = IDLE, last_grant = IFU, aw_done = w_done = 0, and all outputs to 0, asynchronously.
REQ-025 SHALL, on reset mid-transaction, abandon the transaction without completing any response handshake; the first grant after rst rises is at least 1 cycle after the first rising clk edge with rst = 1.

Verification
REQ-026 SHALL cover: IFU-only fetch of 0x3000_0000, slave arready immediate, rvalid 2 cycles later with rdata 0xDEADBEEF -> ifu_rdata = 0xDEADBEEF, arsize = 3'b010, state back in IDLE 1 cycle after the handshake.
REQ-027 SHALL cover: ifu_arvalid and lsu_arvalid rising in the same cycle after reset -> LSU granted first; IFU granted on the following arbitration; a third tie -> LSU again.
REQ-028 SHALL cover: LSU write 0x1000_0000/0x41/wstrb 4'b0001 with wready 3 cycles before awready -> wvalid drops after the W handshake, awvalid stays high until awready, bvalid is forwarded, and only one W beat is issued.
REQ-029 SHALL cover: LSU read with rresp = 2'b11 -> lsu_rresp = 2'b11 and the arbiter returns to IDLE normally.
REQ-030 SHALL cover: rst asserted during LSU_WR after the AW handshake -> all outputs 0 immediately; after release, a new IFU fetch completes correctly with aw_done cleared.
REQ-031 SHALL cover: ifu_arvalid held high during a long LSU read (rvalid delayed 10 cycles) -> ifu_arready stays 0 throughout; IFU granted 1 cycle after the LSU completes.
